// File: rtl/keccak_p_iter.sv
// keccak_p_iter: iterative Keccak-p[25*W,NR] core, one full round per clock.
// Define KECCAK_STALL_EN to add a stall input that freezes a running permutation.
module keccak_p_iter #(
  parameter int W  = 64,
  parameter int NR = 12 + 2 * $clog2(W)
) (
  input  logic            clk,
  input  logic            rst,
`ifdef KECCAK_STALL_EN
  input  logic            stall,
`endif
  input  logic            start,
  input  logic [25*W-1:0] state_in,
  output logic            ready,
  output logic            done,
  output logic [25*W-1:0] state_out,
  output logic [4:0]      round_idx
);
  localparam int L   = $clog2(W);
  localparam int IR0 = 12 + 2 * L - NR;
  localparam int IRL = 11 + 2 * L;

  localparam int RHO [25] = '{
    0, 1, 62, 28, 27,
    36, 44, 6, 55, 20,
    3, 10, 43, 25, 39,
    41, 45, 15, 21, 8,
    18, 2, 61, 56, 14
  };

  function automatic logic [7:0] lfsr_step(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h71 : 8'h00);
  endfunction

  function automatic logic [7:0] lfsr_seed(input int n);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < n; i++) r = lfsr_step(r);
    return r;
  endfunction

  // LFSR state at t = 7*IR0 so a shortened permutation starts mid-sequence
  localparam logic [7:0] SEED = lfsr_seed(7 * IR0);

  function automatic logic [W-1:0] rotl(input logic [W-1:0] v,
                                        input int n);
    if (n == 0) return v;
    return (v << n) | (v >> (W - n));
  endfunction

  typedef enum logic {IDLE, RUN} st_e;

  st_e             st_q;
  logic [25*W-1:0] state_q, state_d;
  logic [4:0]      round_q;
  logic [7:0]      lfsr_q, lfsr_d;
  logic [6:0]      rc;
  logic [W-1:0]    iota;
  logic            ready_q, done_q, stall_w;

  logic [W-1:0] a [25];
  logic [W-1:0] b [25];
  logic [W-1:0] c [5];
  logic [W-1:0] d [5];

`ifdef KECCAK_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  always_comb begin
    rc = '0;
    iota = '0;
    lfsr_d = lfsr_q;
    for (int j = 0; j < 7; j++) begin
      rc[j] = lfsr_d[0];
      lfsr_d = lfsr_step(lfsr_d);
    end
    for (int j = 0; j <= L; j++)
      if (rc[j]) iota = iota | (W'(1) << ((1 << j) - 1));
  end

  always_comb begin
    for (int i = 0; i < 25; i++) begin
      a[i] = state_q[i*W +: W];
      b[i] = '0;
    end
    for (int x = 0; x < 5; x++)
      c[x] = a[x] ^ a[x+5] ^ a[x+10] ^ a[x+15] ^ a[x+20];
    for (int x = 0; x < 5; x++)
      d[x] = c[(x+4)%5] ^ rotl(c[(x+1)%5], 1 % W);
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        b[y + 5*((2*x + 3*y) % 5)] =
          rotl(a[x + 5*y] ^ d[x], RHO[x + 5*y] % W);
    state_d = '0;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        state_d[(x + 5*y)*W +: W] = b[x + 5*y] ^
          (~b[(x+1)%5 + 5*y] & b[(x+2)%5 + 5*y]);
    state_d[W-1:0] = state_d[W-1:0] ^ iota;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= IDLE;
      state_q <= '0;
      round_q <= '0;
      lfsr_q  <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (st_q)
        IDLE: if (start) begin
          state_q <= state_in;
          round_q <= 5'(IR0);
          lfsr_q  <= SEED;
          ready_q <= 1'b0;
          st_q    <= RUN;
        end
        RUN: if (!stall_w) begin
          state_q <= state_d;
          round_q <= round_q + 5'd1;
          lfsr_q  <= lfsr_d;
          if (round_q == 5'(IRL)) begin
            st_q    <= IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign ready     = ready_q;
  assign done      = done_q;
  assign state_out = state_q;
  assign round_idx = round_q;
endmodule

// File: tb/tb_keccak_p_iter.sv
// tb_keccak_p_iter: scoreboard bench for keccak_p_iter at W=64, 8 and 4.
// Expected results come from a lane-level Keccak-p model using FIPS-derived constants.
`timescale 1ns/1ps
module tb_keccak_p_iter;
  localparam int NA = 24;
  localparam int NB = 18;
  localparam int NC = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [1599:0] in_a = '0, out_a;
  logic [199:0]  in_b = '0, out_b;
  logic [99:0]   in_c = '0, out_c;
  logic rdy_a, rdy_b, rdy_c, done_a, done_b, done_c;
  logic [4:0] ri_a, ri_b, ri_c;
`ifdef KECCAK_STALL_EN
  logic stall_a = 1'b0;
`endif
  int cyc = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1599:0] st;
    int            due;
  } exp_t;
  exp_t qa[$], qb[$], qc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  keccak_p_iter #(.W(64), .NR(NA)) u_a (
    .clk(clk), .rst(rst),
`ifdef KECCAK_STALL_EN
    .stall(stall_a),
`endif
    .start(start_a), .state_in(in_a), .ready(rdy_a), .done(done_a),
    .state_out(out_a), .round_idx(ri_a));

  keccak_p_iter #(.W(8), .NR(NB)) u_b (
    .clk(clk), .rst(rst),
`ifdef KECCAK_STALL_EN
    .stall(1'b0),
`endif
    .start(start_b), .state_in(in_b), .ready(rdy_b), .done(done_b),
    .state_out(out_b), .round_idx(ri_b));

  keccak_p_iter #(.W(4), .NR(NC)) u_c (
    .clk(clk), .rst(rst),
`ifdef KECCAK_STALL_EN
    .stall(1'b0),
`endif
    .start(start_c), .state_in(in_c), .ready(rdy_c), .done(done_c),
    .state_out(out_c), .round_idx(ri_c));

  function automatic logic [63:0] msk(input int w);
    return (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  // rc(t) straight from the FIPS 202 definition
  function automatic bit rc_f(input int t);
    bit [7:0] r;
    bit fb;
    r = 8'b0000_0001;
    for (int i = 0; i < t % 255; i++) begin
      fb = r[7];
      r = r << 1;
      if (fb) begin
        r[0] ^= 1'b1; r[4] ^= 1'b1; r[5] ^= 1'b1; r[6] ^= 1'b1;
      end
    end
    return r[0];
  endfunction

  function automatic logic [63:0] rot(input logic [63:0] v,
                                      input int n, input int w);
    if (n == 0) return v & msk(w);
    return ((v << n) | (v >> (w - n))) & msk(w);
  endfunction

  // model layout: lane x+5y at [64*(x+5y) +: 64], low w bits used
  function automatic logic [1599:0] kp(input logic [1599:0] s,
      input int w, input int ir0, input int n);
    logic [63:0] a [5][5];
    logic [63:0] b [5][5];
    logic [63:0] c [5];
    logic [63:0] d [5];
    int off [5][5];
    int x, y, tmp, l;
    logic [1599:0] o;
    l = $clog2(w);
    off[0][0] = 0;
    x = 1; y = 0;
    for (int t = 0; t < 24; t++) begin
      off[x][y] = ((t + 1) * (t + 2) / 2) % w;
      tmp = y; y = (2 * x + 3 * y) % 5; x = tmp;
    end
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        a[i][j] = s[(i + 5*j)*64 +: 64] & msk(w);
    for (int r = ir0; r < ir0 + n; r++) begin
      for (int i = 0; i < 5; i++)
        c[i] = a[i][0] ^ a[i][1] ^ a[i][2] ^ a[i][3] ^ a[i][4];
      for (int i = 0; i < 5; i++)
        d[i] = c[(i+4)%5] ^ rot(c[(i+1)%5], 1 % w, w);
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++)
          b[j][(2*i + 3*j) % 5] = rot(a[i][j] ^ d[i], off[i][j], w);
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++)
          a[i][j] = b[i][j] ^ (~b[(i+1)%5][j] & b[(i+2)%5][j]);
      for (int j = 0; j <= l; j++)
        if (rc_f(j + 7 * r)) a[0][0] ^= (64'd1 << ((1 << j) - 1));
    end
    o = '0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        o[(i + 5*j)*64 +: 64] = a[i][j];
    return o;
  endfunction

  function automatic logic [1599:0] pack(input logic [1599:0] m,
                                         input int w);
    logic [1599:0] o;
    o = '0;
    for (int i = 0; i < 25; i++)
      for (int k = 0; k < w; k++) o[i*w + k] = m[i*64 + k];
    return o;
  endfunction

  function automatic logic [1599:0] rnd(input int w);
    logic [1599:0] o;
    o = '0;
    for (int i = 0; i < 25; i++)
      o[i*64 +: 64] = {$urandom, $urandom} & msk(w);
    return o;
  endfunction

  function automatic logic rdy(input int id);
    return (id == 0) ? rdy_a : (id == 1) ? rdy_b : rdy_c;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic chks(input string nm, input logic [1599:0] got,
                      input logic [1599:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      for (int i = 0; i < 25; i++)
        if (got[i*64 +: 64] !== exp[i*64 +: 64]) begin
          $display("FAIL %s chunk=%0d got=%h exp=%h",
                   nm, i, got[i*64 +: 64], exp[i*64 +: 64]);
          break;
        end
    end
  endtask

  task automatic pop_chk(input int id, input logic [1599:0] got,
                         input logic r);
    exp_t e;
    bit ok;
    string nm;
    ok = 1'b0;
    case (id)
      0: if (qa.size() > 0) begin e = qa.pop_front(); ok = 1'b1; end
      1: if (qb.size() > 0) begin e = qb.pop_front(); ok = 1'b1; end
      default: if (qc.size() > 0) begin e = qc.pop_front(); ok = 1'b1; end
    endcase
    nm = $sformatf("dut%0d", id);
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL %s_unexpected_done got=1 exp=0", nm);
      return;
    end
    chks({nm, "_state"}, got, e.st);
    chk({nm, "_latency"}, 64'(cyc), 64'(e.due));
    chk({nm, "_ready_at_done"}, 64'(r), 64'd1);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (done_a) pop_chk(0, out_a, rdy_a);
      if (done_b) pop_chk(1, 1600'(out_b), rdy_b);
      if (done_c) pop_chk(2, 1600'(out_c), rdy_c);
    end
  end

  // called on a negedge; returns on the negedge after start was sampled
  task automatic issue(input int id, input logic [1599:0] ms,
                       input int extra);
    int w, nr, ir0, n;
    logic [1599:0] din;
    exp_t e;
    w   = (id == 0) ? 64 : (id == 1) ? 8 : 4;
    nr  = (id == 0) ? NA : (id == 1) ? NB : NC;
    ir0 = 12 + 2 * $clog2(w) - nr;
    din = pack(ms, w);
    n = 0;
    while (!rdy(id) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("dut%0d_ready_wait", id), 64'(rdy(id)), 64'd1);
    e.st  = pack(kp(ms, w, ir0, nr), w);
    e.due = cyc + nr + 1 + extra;
    case (id)
      0: begin start_a = 1'b1; in_a = din; qa.push_back(e); end
      1: begin start_b = 1'b1; in_b = din[199:0]; qb.push_back(e); end
      default: begin start_c = 1'b1; in_c = din[99:0]; qc.push_back(e); end
    endcase
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1599:0] z;
    int n;
    z = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(rdy_a), 64'd1);
    chk("rst_done", 64'(done_a), 64'd0);
    chks("rst_state", out_a, '0);
    chk("rst_round", 64'(ri_a), 64'd0);
    rst = 1'b0;

    // zero state, traced round by round
    issue(0, z, 0);
    for (int k = 0; k < NA; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("trace_round_idx%0d", k), 64'(ri_a), 64'(k));
      chks($sformatf("trace_state_r%0d", k), out_a, kp(z, 64, 0, k));
    end
    @(negedge clk);
    chk("zero_lane0_kat", out_a[63:0], 64'hF1258F7940E1DDE7);
    chk("zero_ready_with_done", 64'(rdy_a & done_a), 64'd1);

    // back-to-back: second start lands in the done cycle
    issue(0, rnd(64), 0);
    issue(0, rnd(64), 0);

    // start pulse mid-RUN must be ignored
    issue(0, rnd(64), 0);
    repeat (5) @(negedge clk);
    start_a = 1'b1;
    in_a = rnd(64);
    @(negedge clk);
    start_a = 1'b0;

    for (int i = 0; i < 3; i++) issue(0, rnd(64), 0);

    // reset in the middle of a run
    issue(0, rnd(64), 0);
    repeat (10) @(negedge clk);
    qa.delete();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 64'(rdy_a), 64'd1);
    chk("midrst_done", 64'(done_a), 64'd0);
    chks("midrst_state", out_a, '0);
    chk("midrst_round", 64'(ri_a), 64'd0);
    rst = 1'b0;
    issue(0, rnd(64), 0);

`ifdef KECCAK_STALL_EN
    issue(0, rnd(64), 5);
    repeat (3) @(negedge clk);
    stall_a = 1'b1;
    repeat (5) @(negedge clk);
    stall_a = 1'b0;
`endif

    for (int i = 0; i < 4; i++) issue(1, rnd(8), 0);
    for (int i = 0; i < 4; i++) issue(2, rnd(4), 0);

    n = 0;
    while ((qa.size() + qb.size() + qc.size()) > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(qa.size() + qb.size() + qc.size()), 64'd0);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
